// File: rtl/subtree_response_merger.sv
// -----------------------------------------------------------------------------
// subtree_response_merger
//
// Purpose:
//   Merges the response streams of NUM_CHILD child instances into a single
//   upstream stream. Round-robin arbitration picks a child; a beat with
//   last=0 locks the grant to that child until it delivers its last beat.
//   Every upstream beat carries the index of the child that produced it.
//   The output stage is one register deep and refills in the same cycle it
//   drains, so one beat per cycle flows while up_ready stays high.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   child_valid  per-child beat valid
//   child_data   per-child payload, child i at [i*DATA_W +: DATA_W]
//   child_last   per-child end-of-burst flag
//   child_ready  per-child accept (at most one bit high)
//   up_valid     registered upstream valid
//   up_data      registered upstream payload
//   up_src       index of the child that produced the upstream beat
//   up_last      end-of-burst flag of the upstream beat
//   up_ready     upstream accepts the beat
//   busy         high while a burst holds the grant (LOCKED)
// -----------------------------------------------------------------------------
module subtree_response_merger #(
   parameter int NUM_CHILD = 5,
   parameter int DATA_W    = 16,
   parameter int IDX_W     = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CHILD-1:0]        child_valid,
   input  logic [NUM_CHILD*DATA_W-1:0] child_data,
   input  logic [NUM_CHILD-1:0]        child_last,
   output logic [NUM_CHILD-1:0]        child_ready,
   output logic                        up_valid,
   output logic [DATA_W-1:0]           up_data,
   output logic [IDX_W-1:0]            up_src,
   output logic                        up_last,
   input  logic                        up_ready,
   output logic                        busy
);

   // Child vectors are widened to every index representable in IDX_W bits.
   // Unused slots are tied to zero so an index never selects an undriven bit.
   localparam int              SLOTS    = 2 ** IDX_W;
   localparam logic [IDX_W:0]  NC       = (IDX_W + 1)'(NUM_CHILD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;
   logic                up_valid_q, up_valid_d;
   logic [DATA_W-1:0]   up_data_q, up_data_d;
   logic [IDX_W-1:0]    up_src_q, up_src_d;
   logic                up_last_q, up_last_d;

   logic [SLOTS-1:0]    valid_ext;
   logic [SLOTS-1:0]    last_ext;
   logic [DATA_W-1:0]   data_arr [SLOTS];

   logic                pipe_ready;
   logic                rr_found;
   logic [IDX_W-1:0]    rr_idx;
   logic [IDX_W:0]      cand;
   logic [IDX_W-1:0]    grant_idx;
   logic                grant_valid;
   logic                xfer;
   logic [IDX_W-1:0]    next_idx;

   genvar gi;
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_slot
         if (gi < NUM_CHILD) begin : g_used
            assign valid_ext[gi] = child_valid[gi];
            assign last_ext[gi]  = child_last[gi];
            assign data_arr[gi]  = child_data[gi*DATA_W +: DATA_W];
         end else begin : g_unused
            assign valid_ext[gi] = 1'b0;
            assign last_ext[gi]  = 1'b0;
            assign data_arr[gi]  = '0;
         end
      end
   endgenerate

   // Round-robin search starting at rr_ptr, wrapping at NUM_CHILD.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int k = 0; k < NUM_CHILD; k++) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
         if (cand >= NC) begin
            cand = cand - NC;
         end
         if (!rr_found && valid_ext[cand[IDX_W-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = cand[IDX_W-1:0];
         end
      end
   end

   assign pipe_ready  = !up_valid_q || up_ready;
   // A locked burst only ever considers its owner, even if others are valid.
   assign grant_idx   = (state_q == LOCKED) ? lock_idx_q : rr_idx;
   assign grant_valid = (state_q == LOCKED) ? valid_ext[lock_idx_q] : rr_found;
   assign xfer        = grant_valid && pipe_ready && !rst;
   assign next_idx    = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);

   generate
      for (gi = 0; gi < NUM_CHILD; gi++) begin : g_ready
         assign child_ready[gi] = xfer && (grant_idx == IDX_W'(gi));
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_idx_d = lock_idx_q;
      up_valid_d = up_valid_q;
      up_data_d  = up_data_q;
      up_src_d   = up_src_q;
      up_last_d  = up_last_q;
      if (xfer) begin
         // Load and drain can coincide: the register refills without a bubble.
         up_valid_d = 1'b1;
         up_data_d  = data_arr[grant_idx];
         up_src_d   = grant_idx;
         up_last_d  = last_ext[grant_idx];
         if (last_ext[grant_idx]) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx;
         end else begin
            state_d    = LOCKED;
            lock_idx_d = grant_idx;
         end
      end else if (up_ready) begin
         up_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         lock_idx_q <= '0;
         up_valid_q <= 1'b0;
         up_data_q  <= '0;
         up_src_q   <= '0;
         up_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
         up_valid_q <= up_valid_d;
         up_data_q  <= up_data_d;
         up_src_q   <= up_src_d;
         up_last_q  <= up_last_d;
      end
   end

   assign up_valid = up_valid_q;
   assign up_data  = up_data_q;
   assign up_src   = up_src_q;
   assign up_last  = up_last_q;
   assign busy     = (state_q == LOCKED);

endmodule

// File: tb/tb_subtree_response_merger.sv
// -----------------------------------------------------------------------------
// tb_subtree_response_merger
//
// Purpose:
//   Self-checking bench for subtree_response_merger (5 children, 16-bit data).
//   Each child is a queue of {last, data} beats that advances on handshake.
//   Expected upstream beats are queued in the order they must appear and are
//   compared whenever an upstream beat is accepted. Per-cycle expectations on
//   child_ready / busy / up_* come from hand-derived tables and sequences.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_subtree_response_merger;

   localparam int NC = 5;
   localparam int DW = 16;
   localparam int IW = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [NC-1:0]    child_valid;
   logic [NC*DW-1:0] child_data;
   logic [NC-1:0]    child_last;
   logic [NC-1:0]    child_ready;
   logic             up_valid;
   logic [DW-1:0]    up_data;
   logic [IW-1:0]    up_src;
   logic             up_last;
   logic             up_ready;
   logic             busy;

   always #5 clk = ~clk;

   subtree_response_merger #(
      .NUM_CHILD (NC),
      .DATA_W    (DW),
      .IDX_W     (IW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .child_valid (child_valid),
      .child_data  (child_data),
      .child_last  (child_last),
      .child_ready (child_ready),
      .up_valid    (up_valid),
      .up_data     (up_data),
      .up_src      (up_src),
      .up_last     (up_last),
      .up_ready    (up_ready),
      .busy        (busy)
   );

   typedef struct packed {
      logic [15:0] d;
      logic [2:0]  s;
      logic        l;
   } exp_t;

   typedef struct {
      logic        ur;
      logic [4:0]  rdy;
      logic        uv;
      logic [2:0]  src;
      logic [15:0] data;
   } row_t;

   logic [16:0] cq [NC][$];   // per-child pending beats {last, data}
   exp_t        sbq [$];      // expected upstream beats, in order
   row_t        tab [16];
   logic [NC-1:0] mute;
   logic [NC-1:0] fire;
   int          n_vec;
   int          n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load(input int c, input logic [15:0] d, input logic l);
      cq[c].push_back({l, d});
   endtask

   task automatic expect_beat(input int c, input logic [15:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.s = 3'(c);
      e.l = l;
      sbq.push_back(e);
   endtask

   task automatic drive();
      for (int i = 0; i < NC; i++) begin
         if (cq[i].size() > 0 && !mute[i]) begin
            child_valid[i]           = 1'b1;
            child_data[i*DW +: DW]   = cq[i][0][15:0];
            child_last[i]            = cq[i][0][16];
         end else begin
            // Idle children carry junk that must never reach upstream.
            child_valid[i]           = 1'b0;
            child_data[i*DW +: DW]   = 16'($urandom);
            child_last[i]            = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // First half of a cycle: apply inputs, then at the falling edge sample the
   // handshake and score any upstream beat accepted this cycle.
   task automatic half_a(input logic ur);
      exp_t e;
      up_ready = ur;
      drive();
      @(negedge clk);
      fire = child_valid & child_ready;
      if (!rst && up_valid && up_ready) begin
         if (sbq.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_extra_beat: got src %0d data 0x%0h, expected no beat", up_src, up_data);
         end else begin
            e = sbq.pop_front();
            $display("beat src=%0d data=0x%04h last=%0d", up_src, up_data, up_last);
            chk("sb_src", 32'(up_src), 32'(e.s));
            chk("sb_data", 32'(up_data), 32'(e.d));
            chk("sb_last", 32'(up_last), 32'(e.l));
         end
      end
   endtask

   task automatic half_b();
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++) begin
         if (fire[i]) begin
            void'(cq[i].pop_front());
         end
      end
   endtask

   task automatic cyc(input logic ur, input logic [4:0] rdy, input logic bsy, input string name);
      half_a(ur);
      chk({name, "_ready"}, 32'(child_ready), 32'(rdy));
      chk({name, "_busy"}, 32'(busy), 32'(bsy));
      half_b();
   endtask

   task automatic row(input int r, input logic ur, input logic [4:0] rdy, input logic uv,
                      input logic [2:0] src, input logic [15:0] data);
      tab[r].ur   = ur;
      tab[r].rdy  = rdy;
      tab[r].uv   = uv;
      tab[r].src  = src;
      tab[r].data = data;
   endtask

   initial begin
      n_vec       = 0;
      n_fail      = 0;
      rst         = 1'b1;
      up_ready    = 1'b1;
      mute        = '0;
      fire        = '0;
      child_valid = '0;
      child_data  = '0;
      child_last  = '0;

      // Round-robin with a 4-cycle upstream stall, children 0..4 each holding
      // two single-beat bursts (0x0010+i then 0x0110+i).
      row(0,  1, 5'b00001, 0, 0, 16'h0000);
      row(1,  1, 5'b00010, 1, 0, 16'h0010);
      row(2,  1, 5'b00100, 1, 1, 16'h0011);
      row(3,  0, 5'b00000, 1, 2, 16'h0012);
      row(4,  0, 5'b00000, 1, 2, 16'h0012);
      row(5,  0, 5'b00000, 1, 2, 16'h0012);
      row(6,  0, 5'b00000, 1, 2, 16'h0012);
      row(7,  1, 5'b01000, 1, 2, 16'h0012);
      row(8,  1, 5'b10000, 1, 3, 16'h0013);
      row(9,  1, 5'b00001, 1, 4, 16'h0014);
      row(10, 1, 5'b00010, 1, 0, 16'h0110);
      row(11, 1, 5'b00100, 1, 1, 16'h0111);
      row(12, 1, 5'b01000, 1, 2, 16'h0112);
      row(13, 1, 5'b10000, 1, 3, 16'h0113);
      row(14, 1, 5'b00000, 1, 4, 16'h0114);
      row(15, 1, 5'b00000, 0, 4, 16'h0114);

      @(posedge clk);
      #1;

      // ---- Reset state and single child ----
      load(2, 16'h00A5, 1'b1);
      expect_beat(2, 16'h00A5, 1'b1);
      cyc(1, 5'b00000, 0, "rst_hold0");
      cyc(1, 5'b00000, 0, "rst_hold1");
      chk("rst_up_valid", 32'(up_valid), 32'd0);
      chk("rst_up_data", 32'(up_data), 32'd0);
      chk("rst_up_src", 32'(up_src), 32'd0);
      chk("rst_up_last", 32'(up_last), 32'd0);
      rst = 1'b0;
      cyc(1, 5'b00100, 0, "single_grant");
      half_a(1);
      chk("single_up_valid", 32'(up_valid), 32'd1);
      chk("single_up_src", 32'(up_src), 32'd2);
      half_b();
      // rr_ptr is now 3: child 3 must win over child 1, then child 1.
      load(1, 16'h0301, 1'b1);
      load(3, 16'h0303, 1'b1);
      expect_beat(3, 16'h0303, 1'b1);
      expect_beat(1, 16'h0301, 1'b1);
      cyc(1, 5'b01000, 0, "rr3_first");
      cyc(1, 5'b00010, 0, "rr3_second");
      cyc(1, 5'b00000, 0, "rr3_drain");

      // ---- Round-robin with backpressure (table) ----
      rst = 1'b1;
      cyc(1, 5'b00000, 0, "rst2");
      rst = 1'b0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < NC; i++) begin
            load(i, 16'(p * 16'h0100 + 16'h0010 + i), 1'b1);
            expect_beat(i, 16'(p * 16'h0100 + 16'h0010 + i), 1'b1);
         end
      end
      for (int r = 0; r < 16; r++) begin
         half_a(tab[r].ur);
         chk($sformatf("rr_row%0d_ready", r), 32'(child_ready), 32'(tab[r].rdy));
         chk($sformatf("rr_row%0d_up_valid", r), 32'(up_valid), 32'(tab[r].uv));
         chk($sformatf("rr_row%0d_up_src", r), 32'(up_src), 32'(tab[r].src));
         chk($sformatf("rr_row%0d_up_data", r), 32'(up_data), 32'(tab[r].data));
         half_b();
      end

      // ---- Burst lock ----
      rst = 1'b1;
      cyc(1, 5'b00000, 0, "rst3");
      rst = 1'b0;
      load(0, 16'h0A00, 1'b1);
      expect_beat(0, 16'h0A00, 1'b1);
      cyc(1, 5'b00001, 0, "pre");            // rr_ptr -> 1
      load(1, 16'h0B01, 1'b0);
      load(1, 16'h0B02, 1'b0);
      load(1, 16'h0B03, 1'b1);
      load(0, 16'h0C00, 1'b1);
      load(4, 16'h0C04, 1'b1);
      expect_beat(1, 16'h0B01, 1'b0);
      expect_beat(1, 16'h0B02, 1'b0);
      expect_beat(1, 16'h0B03, 1'b1);
      expect_beat(4, 16'h0C04, 1'b1);
      expect_beat(0, 16'h0C00, 1'b1);
      cyc(1, 5'b00010, 0, "burst_b1");
      cyc(1, 5'b00010, 1, "burst_b2");
      cyc(1, 5'b00010, 1, "burst_b3");
      cyc(1, 5'b10000, 0, "burst_then4");    // rr_ptr was 2 after the burst
      cyc(1, 5'b00001, 0, "burst_then0");
      cyc(1, 5'b00000, 0, "burst_drain");

      // ---- LOCKED gap: owner drops valid, others must wait ----
      load(3, 16'h0D01, 1'b0);
      load(3, 16'h0D02, 1'b1);
      load(0, 16'h0E00, 1'b1);
      expect_beat(3, 16'h0D01, 1'b0);
      expect_beat(3, 16'h0D02, 1'b1);
      expect_beat(0, 16'h0E00, 1'b1);
      cyc(1, 5'b01000, 0, "gap_b1");
      mute[3] = 1'b1;
      cyc(1, 5'b00000, 1, "gap_wait1");
      cyc(1, 5'b00000, 1, "gap_wait2");
      mute[3] = 1'b0;
      cyc(1, 5'b01000, 1, "gap_b2");
      cyc(1, 5'b00001, 0, "gap_then0");
      cyc(1, 5'b00000, 0, "gap_drain");

      // ---- Reset mid-burst ----
      load(2, 16'h0F01, 1'b0);               // this beat is discarded by reset
      load(2, 16'h0F02, 1'b0);
      load(2, 16'h0F03, 1'b1);
      cyc(1, 5'b00100, 0, "mid_b1");
      rst = 1'b1;
      cyc(1, 5'b00000, 1, "mid_rst");
      rst = 1'b0;
      cq[2].delete();
      load(0, 16'h1100, 1'b1);
      load(2, 16'h1201, 1'b1);
      expect_beat(0, 16'h1100, 1'b1);
      expect_beat(2, 16'h1201, 1'b1);
      half_a(1);
      chk("mid_up_valid", 32'(up_valid), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_ready", 32'(child_ready), 32'(5'b00001));
      half_b();
      cyc(1, 5'b00100, 0, "mid_then2");
      cyc(1, 5'b00000, 0, "mid_drain");

      chk("sb_pending", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
